// File: rtl/switch_input_pkg.sv
// switch_input_pkg: register offsets and CTRL bit positions for the switch input peripheral.
package switch_input_pkg;
  localparam logic [1:0] SW_LO = 2'd0;
  localparam logic [1:0] SW_HI = 2'd1;
  localparam logic [1:0] KEY   = 2'd2;
  localparam logic [1:0] CTRL  = 2'd3;
  localparam int EN   = 0;
  localparam int PEND = 1;
  function automatic logic [31:0] ctrl_word(input logic pend, input logic en);
    return {30'b0, pend, en};
  endfunction
endpackage

// File: rtl/switch_input_if.sv
// switch_input_if: CPU bus port of the switch input peripheral.
interface switch_input_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        irq;
  modport master (output addr, we, byteen, WD, input RD, irq);
  modport slave  (input addr, we, byteen, WD, output RD, irq);
endinterface

// File: rtl/switch_input_sync_debounce.sv
// sync_debounce: two-flop synchroniser plus shared-counter debounce over a W-bit vector.
module sync_debounce #(
  parameter int W          = 72,
  parameter int DEBOUNCE_N = 500000,
  parameter int CNT_W      = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb,
  output logic         changed
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_N - 1);
  logic [W-1:0]     s1, s2, snap;
  logic [CNT_W-1:0] cnt;
  logic             stable, full;
  assign stable  = s2 == snap;
  assign full    = cnt == LAST;
  // Pulses in the cycle whose closing edge loads a new value into deb.
  assign changed = stable && full && s2 != deb;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      snap <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      snap <= s2;
      cnt  <= !stable ? '0 : full ? cnt : cnt + 1'b1;
      if (stable && full) deb <= s2;
    end
  end
endmodule

// File: rtl/switch_input.sv
// switch_input: debounced DIP switch / push-button port with maskable change interrupt.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int DEBOUNCE_N = 500000,
  parameter int CNT_W      = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   dip_sw,
  input  logic [7:0]    key,
  switch_input_if.slave bus
);
  logic [71:0] deb;
  logic        changed, enable, pending, ctrl_wr;
  sync_debounce #(.W(72), .DEBOUNCE_N(DEBOUNCE_N), .CNT_W(CNT_W)) u_deb (
    .clk     (clk),
    .reset   (reset),
    .raw     ({key, dip_sw}),
    .deb     (deb),
    .changed (changed)
  );
  assign ctrl_wr = bus.we && bus.byteen[0] && bus.addr == CTRL;
  // A change detected with enable set beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= bus.WD[EN];
      pending <= (changed && enable) ? 1'b1 : (ctrl_wr && bus.WD[PEND]) ? 1'b0 : pending;
    end
  end
  always_comb begin
    bus.RD = bus.addr == SW_LO ? deb[31:0] :
             bus.addr == SW_HI ? deb[63:32] :
             bus.addr == KEY   ? {24'b0, deb[71:64]} : ctrl_word(pending, enable);
  end
  assign bus.irq = pending & enable;
endmodule

// File: tb/tb_switch_input.sv
// tb_switch_input: directed checks of switch_input with DEBOUNCE_N=4.
module tb_switch_input;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] dip_sw = '0;
  logic [7:0]  key = '0;
  int          vectors = 0;
  int          miscompares = 0;
  switch_input_if bus ();
  switch_input #(.DEBOUNCE_N(4), .CNT_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .dip_sw (dip_sw),
    .key    (key),
    .bus    (bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus.addr = a; bus.we = 1'b1; bus.byteen = be; bus.WD = wd;
    tick();
    bus.we = 1'b0; bus.byteen = '0; bus.WD = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dip_sw = '0; key = '0;
    bus.addr = '0; bus.we = 1'b0; bus.byteen = '0; bus.WD = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      vectors++;
      if (bus.RD !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd[%0d] got %h want 00000000", a, bus.RD);
      end
    end
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq got %b want 0", bus.irq);
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    bus.addr = 2'd0;
    dip_sw = 64'h0afd2403_054b0c7b;
    for (int i = 0; i <= 6; i++) begin
      tick();
      exp = (i == 6) ? 32'h054b0c7b : 32'h0;
      vectors++;
      if (bus.RD !== exp) begin
        miscompares++;
        $display("FAIL latency_lo edge t+%0d got %h want %h", i, bus.RD, exp);
      end
    end
    bus.addr = 2'd1; #1;
    vectors++;
    if (bus.RD !== 32'h0afd2403) begin
      miscompares++;
      $display("FAIL latency_hi got %h want 0afd2403", bus.RD);
    end
  endtask

  task automatic test_glitch();
    bus_write(2'd3, 32'h1, 4'h1);
    bus.addr = 2'd2;
    key = 8'h01;
    repeat (3) tick();
    key = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus.RD !== 32'h0) begin
        miscompares++;
        $display("FAIL glitch_key cycle %0d got %h want 00000000", i, bus.RD);
      end
    end
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h1 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_ctrl got rd=%h irq=%b want rd=00000001 irq=0", bus.RD, bus.irq);
    end
  endtask

  task automatic test_irq();
    logic exp;
    bus_write(2'd3, 32'h1, 4'h1);
    bus.addr = 2'd3;
    key = 8'h81;
    for (int i = 0; i <= 6; i++) begin
      tick();
      exp = (i == 6);
      vectors++;
      if (bus.irq !== exp) begin
        miscompares++;
        $display("FAIL irq_rise edge t+%0d got %b want %b", i, bus.irq, exp);
      end
    end
    vectors++;
    if (bus.RD !== 32'h3) begin
      miscompares++;
      $display("FAIL irq_ctrl got %h want 00000003", bus.RD);
    end
    bus.addr = 2'd2; #1;
    vectors++;
    if (bus.RD !== 32'h81) begin
      miscompares++;
      $display("FAIL irq_key got %h want 00000081", bus.RD);
    end
    bus_write(2'd3, 32'h3, 4'h1);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h1 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear got rd=%h irq=%b want rd=00000001 irq=0", bus.RD, bus.irq);
    end
  endtask

  task automatic test_set_vs_clear();
    key = 8'h00;
    repeat (6) tick();
    bus_write(2'd3, 32'h3, 4'h1);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h3 || bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins got rd=%h irq=%b want rd=00000003 irq=1", bus.RD, bus.irq);
    end
    bus_write(2'd3, 32'h0, 4'h0);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h3) begin
      miscompares++;
      $display("FAIL byteen0 got %h want 00000003", bus.RD);
    end
    bus_write(2'd0, 32'h0, 4'hf);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h3) begin
      miscompares++;
      $display("FAIL ro_write got %h want 00000003", bus.RD);
    end
  endtask

  task automatic test_mask();
    bus_write(2'd3, 32'h0, 4'h1);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h2 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_keep got rd=%h irq=%b want rd=00000002 irq=0", bus.RD, bus.irq);
    end
    bus_write(2'd3, 32'h1, 4'h1);
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL unmask got irq=%b want 1", bus.irq);
    end
    bus_write(2'd3, 32'h2, 4'h1);
    bus.addr = 2'd3; #1;
    vectors++;
    if (bus.RD !== 32'h0) begin
      miscompares++;
      $display("FAIL disable_clear got %h want 00000000", bus.RD);
    end
    dip_sw = 64'h12345678_9abcdef0;
    repeat (8) tick();
    vectors++;
    if (bus.RD !== 32'h0 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL masked_change got rd=%h irq=%b want rd=00000000 irq=0", bus.RD, bus.irq);
    end
    bus.addr = 2'd0; #1;
    vectors++;
    if (bus.RD !== 32'h9abcdef0) begin
      miscompares++;
      $display("FAIL masked_deb got %h want 9abcdef0", bus.RD);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    dip_sw = 64'hdeadbeef_cafef00d;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      vectors++;
      if (bus.RD !== 32'h0) begin
        miscompares++;
        $display("FAIL midreset_rd[%0d] got %h want 00000000", a, bus.RD);
      end
    end
    bus.addr = 2'd0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      exp = (i == 6) ? 32'hcafef00d : 32'h0;
      vectors++;
      if (bus.RD !== exp) begin
        miscompares++;
        $display("FAIL midreset_lo edge u+%0d got %h want %h", i, bus.RD, exp);
      end
    end
    bus.addr = 2'd1; #1;
    vectors++;
    if (bus.RD !== 32'hdeadbeef || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_hi got rd=%h irq=%b want rd=deadbeef irq=0", bus.RD, bus.irq);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_set_vs_clear();
    test_mask();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
